cfg_stream_sequencer: RTL and testbench

- Upstream driver of the array's host-side input: replays a buffered configuration program onto the host_controller bus, streams a block of SPM preload words onto ex_bus, then issues a single-cycle run pulse.
- Replaces hand-written stimulus sequencing with hardware.
- Outputs feed the array front end, either directly or through the existing delay/alignment stage.

---
 rtl/cfg_stream_sequencer_if.sv | 32 +++
 rtl/cfg_stream_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cfg_stream_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_stream_sequencer_if.sv
// Host-side bundle between the configuration/preload source and cfg_stream_sequencer.
// The sequencer uses the slave view; the upstream source or bench uses the master view.
interface cfg_stream_sequencer_if #(
    parameter int INST_W = 48,
    parameter int TGT_W  = 10,
    parameter int A_W    = 10,
    parameter int HOLD_W = 4
);
    logic                             cfg_wr_valid;
    logic                             cfg_wr_ready;
    logic [TGT_W+INST_W+HOLD_W-1:0]   cfg_wr_data;
    logic                             start;
    logic [A_W:0]                     data_len;
    logic                             data_valid;
    logic                             data_ready;
    logic [31:0]                      data_in;
    logic [TGT_W+INST_W-1:0]          host_controller;
    logic [2+A_W+32-1:0]              ex_bus;
    logic                             run;
    logic                             busy;
    logic                             done;

    modport master (
        output cfg_wr_valid, cfg_wr_data, start, data_len, data_valid, data_in,
        input  cfg_wr_ready, data_ready, host_controller, ex_bus, run, busy, done
    );

    modport slave (
        input  cfg_wr_valid, cfg_wr_data, start, data_len, data_valid, data_in,
        output cfg_wr_ready, data_ready, host_controller, ex_bus, run, busy, done
    );
endinterface

// File: rtl/cfg_stream_sequencer.sv
// Replays a buffered config program onto host_controller, streams SPM preload words
// onto ex_bus, then pulses run and done.
module cfg_stream_sequencer #(
    parameter int INST_W = 48,
    parameter int TGT_W  = 10,
    parameter int A_W    = 10,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cfg_stream_sequencer_if.slave bus
);
    localparam int CFG_W = TGT_W + INST_W + HOLD_W;
    localparam int HC_W  = TGT_W + INST_W;
    localparam int EX_W  = 2 + A_W + 32;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = A_W + 1;

    typedef enum logic [2:0] {IDLE, CFG, GAP, DATA, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
    logic [LEN_W-1:0]   len, len_next;
    logic [LEN_W-1:0]   words, words_next;
    logic [A_W-1:0]     addr, addr_next;

    logic [HC_W-1:0]    hc_q, hc_next;
    logic [EX_W-1:0]    ex_q, ex_next;
    logic               run_q, run_next;
    logic               done_q, done_next;
    logic               busy_q, busy_next;
    logic               cfg_ready_q, cfg_ready_next;
    logic               data_ready_q, data_ready_next;

    logic [CFG_W-1:0]   mem [DEPTH];
    logic [CFG_W-1:0]   cur;
    logic [HOLD_W-1:0]  cur_hold;
    logic               wr_fire;
    logic               data_fire;
    logic               entry_last;

    assign wr_fire    = bus.cfg_wr_valid && cfg_ready_q;
    assign data_fire  = bus.data_valid && data_ready_q;
    assign cur        = mem[rd_ptr];
    assign cur_hold   = cur[HOLD_W-1:0];
    // A hold of zero still occupies the bus for one cycle.
    assign entry_last = (cur_hold == '0) || (hold_cnt == cur_hold - HOLD_W'(1));

    assign bus.host_controller = hc_q;
    assign bus.ex_bus          = ex_q;
    assign bus.run             = run_q;
    assign bus.done            = done_q;
    assign bus.busy            = busy_q;
    assign bus.cfg_wr_ready    = cfg_ready_q;
    assign bus.data_ready      = data_ready_q;

    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem[count[PTR_W-1:0]] <= bus.cfg_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            hold_cnt     <= '0;
            len          <= '0;
            words        <= '0;
            addr         <= '0;
            hc_q         <= '0;
            ex_q         <= '0;
            run_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            cfg_ready_q  <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            rd_ptr       <= rd_ptr_next;
            hold_cnt     <= hold_cnt_next;
            len          <= len_next;
            words        <= words_next;
            addr         <= addr_next;
            hc_q         <= hc_next;
            ex_q         <= ex_next;
            run_q        <= run_next;
            done_q       <= done_next;
            busy_q       <= busy_next;
            cfg_ready_q  <= cfg_ready_next;
            data_ready_q <= data_ready_next;
        end
    end

    // Handshake readies and busy track the next state so they never lag an acceptance.
    always_comb begin
        state_next    = state;
        count_next    = count;
        rd_ptr_next   = rd_ptr;
        hold_cnt_next = hold_cnt;
        len_next      = len;
        words_next    = words;
        addr_next     = addr;
        hc_next       = '0;
        ex_next       = '0;
        run_next      = 1'b0;
        done_next     = 1'b0;

        if (wr_fire) begin
            count_next = count + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    len_next      = bus.data_len;
                    rd_ptr_next   = '0;
                    hold_cnt_next = '0;
                    words_next    = '0;
                    addr_next     = '0;
                    if (count_next != '0) begin
                        state_next = CFG;
                    end else if (bus.data_len != '0) begin
                        state_next = DATA;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            CFG: begin
                hc_next = cur[CFG_W-1:HOLD_W];
                if (entry_last) begin
                    hold_cnt_next = '0;
                    rd_ptr_next   = rd_ptr + PTR_W'(1);
                    if ({1'b0, rd_ptr} == count - CNT_W'(1)) begin
                        state_next = GAP;
                    end
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            GAP: begin
                state_next = (len != '0) ? DATA : RUN;
            end
            DATA: begin
                if (data_fire) begin
                    ex_next    = {1'b1, 1'b0, addr, bus.data_in};
                    addr_next  = addr + A_W'(1);
                    words_next = words + LEN_W'(1);
                    if (words + LEN_W'(1) == len) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                run_next   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_next  = 1'b1;
                count_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cfg_ready_next  = (state_next == IDLE) && (count_next < CNT_W'(DEPTH));
        data_ready_next = (state_next == DATA);
        busy_next       = (state_next != IDLE);
    end
endmodule

// File: tb/tb_cfg_stream_sequencer.sv
// Directed bench for cfg_stream_sequencer: replay order/holds, preload streaming,
// buffer overflow, start while busy and reset mid-transfer.
module tb_cfg_stream_sequencer;
    localparam int INST_W = 48;
    localparam int TGT_W  = 10;
    localparam int A_W    = 10;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 4;
    localparam int CW     = TGT_W + INST_W + HOLD_W;
    localparam int HW     = TGT_W + INST_W;
    localparam int EW     = 2 + A_W + 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertions = 0;
    int   failures = 0;

    cfg_stream_sequencer_if #(.INST_W(INST_W), .TGT_W(TGT_W), .A_W(A_W), .HOLD_W(HOLD_W)) bus ();

    cfg_stream_sequencer #(
        .INST_W(INST_W), .TGT_W(TGT_W), .A_W(A_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mk(input logic [TGT_W-1:0] t, input logic [INST_W-1:0] i,
                                         input logic [HOLD_W-1:0] h);
        return {t, i, h};
    endfunction

    task automatic write_entry(input logic [CW-1:0] d, input int bound, output bit ok);
        ok = 1'b0;
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_data  = d;
        for (int i = 0; i < bound && !ok; i++) begin
            if (bus.cfg_wr_ready === 1'b1) ok = 1'b1;
            step();
        end
        bus.cfg_wr_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [A_W:0] len);
        bus.data_len = len;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1;
        step();
        step();
        obs = {bus.run, bus.done, bus.busy, bus.cfg_wr_ready, bus.data_ready,
               |bus.host_controller, |bus.ex_bus};
        assertions++;
        if (obs !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 7'b0);
        end
        rst = 1'b0;
        step();
        assertions++;
        if ({bus.cfg_wr_ready, bus.busy} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 10", {bus.cfg_wr_ready, bus.busy});
        end
    endtask

    task automatic test_cfg_replay();
        logic [TGT_W-1:0] tg [5];
        logic [HW-1:0]    exp_q [$];
        bit               ok;
        tg = '{10'h188, 10'h184, 10'h148, 10'h144, 10'h128};
        for (int i = 0; i < 5; i++) begin
            write_entry(mk(tg[i], 48'h004708078d9f + 48'(i), 4'd3), 8, ok);
            assertions++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL replay_write%0d: got not accepted expected accepted", i);
            end
            for (int r = 0; r < 3; r++) exp_q.push_back({tg[i], 48'h004708078d9f + 48'(i)});
        end
        exp_q.push_back('0);
        pulse_start('0);
        assertions++;
        if ({bus.busy, bus.cfg_wr_ready, bus.host_controller} !== {1'b1, 1'b0, {HW{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL replay_begin: got busy=%b ready=%b hc=%h expected busy=1 ready=0 hc=0",
                     bus.busy, bus.cfg_wr_ready, bus.host_controller);
        end
        foreach (exp_q[i]) begin
            step();
            assertions++;
            if ({bus.host_controller, bus.run, bus.busy} !== {exp_q[i], 1'b0, 1'b1}) begin
                failures++;
                $display("[TB] FAIL replay_cycle%0d: got hc=%h run=%b busy=%b expected hc=%h run=0 busy=1",
                         i, bus.host_controller, bus.run, bus.busy, exp_q[i]);
            end
        end
        step();
        assertions++;
        if ({bus.run, bus.done, bus.host_controller} !== {1'b1, 1'b0, {HW{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL replay_run: got run=%b done=%b hc=%h expected run=1 done=0 hc=0",
                     bus.run, bus.done, bus.host_controller);
        end
        step();
        assertions++;
        if ({bus.run, bus.done, bus.busy} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL replay_done: got run/done/busy=%b expected 010", {bus.run, bus.done, bus.busy});
        end
    endtask

    task automatic test_hold_zero();
        logic [HW-1:0] a, b, c;
        logic [HW-1:0] exp_q [$];
        bit            ok;
        a = {10'h101, 48'h0000_1111_2222};
        b = {10'h102, 48'h0000_3333_4444};
        c = {10'h104, 48'h0000_5555_6666};
        write_entry({a, 4'd2}, 8, ok);
        write_entry({b, 4'd0}, 8, ok);
        write_entry({c, 4'd2}, 8, ok);
        exp_q = '{a, a, b, c, c, {HW{1'b0}}};
        pulse_start('0);
        foreach (exp_q[i]) begin
            step();
            assertions++;
            if (bus.host_controller !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL hold0_cycle%0d: got %h expected %h", i, bus.host_controller, exp_q[i]);
            end
        end
        step();
        assertions++;
        if (bus.run !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold0_run: got %b expected 1", bus.run);
        end
        step();
    endtask

    task automatic test_data_stream();
        logic [EW-1:0]  exp_ex;
        logic [A_W-1:0] addr;
        int             words;
        int             cyc;
        addr  = '0;
        words = 0;
        cyc   = 0;
        pulse_start(11'd100);
        bus.data_len = 11'd5;
        while (words < 100 && cyc < 400) begin
            bus.data_valid = (cyc % 2 == 1);
            bus.data_in    = 32'(words + 1);
            assertions++;
            if (bus.data_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL data_ready_c%0d: got %b expected 1", cyc, bus.data_ready);
            end
            step();
            if (cyc % 2 == 1) begin
                exp_ex = {2'b10, addr, 32'(words + 1)};
                addr   = addr + 1'b1;
                words++;
            end else begin
                exp_ex = '0;
            end
            assertions++;
            if (bus.ex_bus !== exp_ex) begin
                failures++;
                $display("[TB] FAIL data_ex_c%0d: got %h expected %h", cyc, bus.ex_bus, exp_ex);
            end
            cyc++;
        end
        bus.data_valid = 1'b0;
        assertions++;
        if (words != 100 || bus.data_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL data_end: got words=%0d ready=%b expected words=100 ready=0", words, bus.data_ready);
        end
        step();
        assertions++;
        if ({bus.run, bus.ex_bus} !== {1'b1, {EW{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL data_run: got run=%b ex=%h expected run=1 ex=0", bus.run, bus.ex_bus);
        end
        step();
        assertions++;
        if ({bus.run, bus.done} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL data_done: got run/done=%b expected 01", {bus.run, bus.done});
        end
    endtask

    task automatic test_overflow();
        logic [HW-1:0] exp_q [$];
        bit            ok;
        for (int i = 0; i < DEPTH; i++) begin
            write_entry(mk(TGT_W'(i + 1), INST_W'(48'hA000 + i), 4'd1), 8, ok);
            assertions++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL ovf_write%0d: got not accepted expected accepted", i);
            end
            exp_q.push_back({TGT_W'(i + 1), INST_W'(48'hA000 + i)});
        end
        exp_q.push_back('0);
        assertions++;
        if (bus.cfg_wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_full_ready: got %b expected 0", bus.cfg_wr_ready);
        end
        write_entry(mk(10'h3FF, 48'hDEAD_BEEF_0000, 4'd1), 4, ok);
        assertions++;
        if (ok) begin
            failures++;
            $display("[TB] FAIL ovf_17th: got accepted expected stalled");
        end
        pulse_start('0);
        foreach (exp_q[i]) begin
            step();
            assertions++;
            if (bus.host_controller !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL ovf_cycle%0d: got %h expected %h", i, bus.host_controller, exp_q[i]);
            end
        end
        step();
        assertions++;
        if (bus.run !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_run: got %b expected 1", bus.run);
        end
        step();
    endtask

    task automatic test_start_while_busy();
        logic [HW-1:0] a, b;
        logic [HW-1:0] exp_q [$];
        bit            ok;
        int            extra;
        a = {10'h201, 48'h0000_AAAA_0001};
        b = {10'h202, 48'h0000_BBBB_0002};
        write_entry({a, 4'd3}, 8, ok);
        // Start and a write in the same cycle: the write joins the program.
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_data  = {b, 4'd3};
        bus.data_len     = '0;
        bus.start        = 1'b1;
        assertions++;
        if (bus.cfg_wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_same_cycle_ready: got %b expected 1", bus.cfg_wr_ready);
        end
        step();
        bus.cfg_wr_valid = 1'b0;
        bus.start        = 1'b0;
        exp_q = '{a, a, a, b, b, b, {HW{1'b0}}};
        foreach (exp_q[i]) begin
            bus.start = (i == 2);
            step();
            bus.start = 1'b0;
            assertions++;
            if (bus.host_controller !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL busy_cycle%0d: got %h expected %h", i, bus.host_controller, exp_q[i]);
            end
        end
        step();
        assertions++;
        if ({bus.run, bus.done} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL busy_run: got run/done=%b expected 10", {bus.run, bus.done});
        end
        step();
        assertions++;
        if ({bus.run, bus.done} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL busy_done: got run/done=%b expected 01", {bus.run, bus.done});
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.run === 1'b1 || bus.done === 1'b1) extra++;
        end
        assertions++;
        if (extra != 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_extra_pulses: got %0d busy=%b expected 0 busy=0", extra, bus.busy);
        end
    endtask

    task automatic test_reset_mid_data();
        bit         ok;
        logic [6:0] obs;
        write_entry(mk(10'h111, 48'h1, 4'd1), 8, ok);
        write_entry(mk(10'h112, 48'h2, 4'd1), 8, ok);
        pulse_start(11'd10);
        step();
        step();
        step();
        assertions++;
        if (bus.data_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_in_data: got ready=%b expected 1", bus.data_ready);
        end
        bus.data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 32'h100 + 32'(i);
            step();
        end
        assertions++;
        if (bus.ex_bus !== {2'b10, 10'd2, 32'h102}) begin
            failures++;
            $display("[TB] FAIL rstmid_word3: got %h expected %h", bus.ex_bus, {2'b10, 10'd2, 32'h102});
        end
        bus.data_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs = {bus.run, bus.done, bus.busy, bus.cfg_wr_ready, bus.data_ready,
               |bus.host_controller, |bus.ex_bus};
        assertions++;
        if (obs !== 7'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_outputs: got %b expected %b", obs, 7'b0);
        end
        step();
        assertions++;
        if ({bus.cfg_wr_ready, bus.busy} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rstmid_ready: got %b expected 10", {bus.cfg_wr_ready, bus.busy});
        end
        // An empty buffer and zero length go straight to the run pulse.
        pulse_start('0);
        step();
        assertions++;
        if ({bus.run, bus.host_controller} !== {1'b1, {HW{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL rstmid_discard: got run=%b hc=%h expected run=1 hc=0", bus.run, bus.host_controller);
        end
        step();
        assertions++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_done: got %b expected 1", bus.done);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cfg_wr_valid = 1'b0;
        bus.cfg_wr_data  = '0;
        bus.start        = 1'b0;
        bus.data_len     = '0;
        bus.data_valid   = 1'b0;
        bus.data_in      = '0;
        test_reset();
        test_cfg_replay();
        test_hold_zero();
        test_data_stream();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
